// File: rtl/ula_controle_pkg.sv
// Shared command codes, state encoding and default widths for the ULA controller
// and the register slices it drives.
package ula_controle_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned OPW_DEF   = 3;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_HOLD  = 2'd2
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LIMPA   = 3'd1,
        S_CARGA_X = 3'd2,
        S_CARGA_Y = 3'd3,
        S_EXEC    = 3'd4,
        S_FIM     = 3'd5
    } state_e;

endpackage

// File: rtl/ula_controle.sv
// Sequencer for the regX/regY/regZ + ULA datapath: latches operands on start, then
// clears, loads X, loads Y, executes into Z and pulses done.
module ula_controle
    import ula_controle_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operando_a,
    input  logic [WIDTH-1:0] operando_b,
    input  logic [OPW-1:0]   opcode,
    output logic [WIDTH-1:0] barramento,
    output logic [1:0]       Tx,
    output logic [1:0]       Ty,
    output logic [1:0]       Tz,
    output logic [OPW-1:0]   sel_ula,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_lat_q, a_lat_d;
    logic [WIDTH-1:0] b_lat_q, b_lat_d;
    logic [OPW-1:0]   op_lat_q, op_lat_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic [OPW-1:0]   sel_q, sel_d;
    cmd_e             tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = S_IDLE;
        a_lat_d  = a_lat_q;
        b_lat_d  = b_lat_q;
        op_lat_d = op_lat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_lat_d  = operando_a;
                    b_lat_d  = operando_b;
                    op_lat_d = opcode;
                    state_d  = S_LIMPA;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_LIMPA:   state_d = S_CARGA_X;
            S_CARGA_X: state_d = S_CARGA_Y;
            S_CARGA_Y: state_d = S_EXEC;
            S_EXEC:    state_d = S_FIM;
            S_FIM:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up
    // with the cycle the FSM actually spends in that state.
    always_comb begin
        tx_d   = CMD_HOLD;
        ty_d   = CMD_HOLD;
        tz_d   = CMD_HOLD;
        bus_d  = bus_q;
        sel_d  = sel_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIM);
        case (state_d)
            S_LIMPA: begin
                tx_d  = CMD_CLEAR;
                ty_d  = CMD_CLEAR;
                tz_d  = CMD_CLEAR;
                bus_d = '0;
            end
            S_CARGA_X: begin
                bus_d = a_lat_q;
                tx_d  = CMD_LOAD;
            end
            S_CARGA_Y: begin
                bus_d = b_lat_q;
                ty_d  = CMD_LOAD;
            end
            S_EXEC: begin
                sel_d = op_lat_q;
                tz_d  = CMD_LOAD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_lat_q  <= '0;
            b_lat_q  <= '0;
            op_lat_q <= '0;
            bus_q    <= '0;
            sel_q    <= '0;
            tx_q     <= CMD_CLEAR;
            ty_q     <= CMD_CLEAR;
            tz_q     <= CMD_CLEAR;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_lat_q  <= a_lat_d;
            b_lat_q  <= b_lat_d;
            op_lat_q <= op_lat_d;
            bus_q    <= bus_d;
            sel_q    <= sel_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            tz_q     <= tz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign barramento = bus_q;
    assign sel_ula    = sel_q;
    assign Tx         = tx_q;
    assign Ty         = ty_q;
    assign Tz         = tz_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ula_controle.sv
// Bench for ula_controle: offset-from-accept reference model plus a small X/Y/Z + ULA
// datapath driven by the DUT commands, so the Z result is checked end to end.
module tb_ula_controle;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [3:0] operando_a, operando_b, barramento;
    logic [2:0] opcode, sel_ula;
    logic [1:0] Tx, Ty, Tz;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ula_controle #(.WIDTH(4), .OPW(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .operando_a (operando_a),
        .operando_b (operando_b),
        .opcode     (opcode),
        .barramento (barramento),
        .Tx         (Tx),
        .Ty         (Ty),
        .Tz         (Tz),
        .sel_ula    (sel_ula),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [3:0] ula(input logic [3:0] p, input logic [3:0] q, input logic [2:0] op);
        case (op)
            3'd0:    return p + q;
            3'd1:    return p - q;
            3'd2:    return p & q;
            3'd3:    return p | q;
            3'd4:    return p ^ q;
            3'd5:    return ~p;
            3'd6:    return p;
            default: return q;
        endcase
    endfunction

    // Register slices as the board would have them: CLEAR=0, LOAD=1, else hold.
    logic [3:0] x_r = '0, y_r = '0, z_r = '0;
    always @(posedge clock) begin
        if (Tx == 2'd0) x_r <= '0; else if (Tx == 2'd1) x_r <= barramento;
        if (Ty == 2'd0) y_r <= '0; else if (Ty == 2'd1) y_r <= barramento;
        if (Tz == 2'd0) z_r <= '0; else if (Tz == 2'd1) z_r <= ula(x_r, y_r, sel_ula);
    end

    // Reference model: ph = cycles since the accepting edge (0 = idle).
    int         ph = 0;
    bit         mrst = 1'b0;
    logic [3:0] ma = '0, mb = '0, mbus = '0;
    logic [2:0] mop = '0, msel = '0;
    int         cyc = 0;
    int         last_done = 0;
    bit         track = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        int etx, ety, etz;
        @(posedge clock);
        cyc++;
        if (reset) begin
            ph = 0; mrst = 1'b1;
            ma = '0; mb = '0; mop = '0; mbus = '0; msel = '0;
        end else begin
            mrst = 1'b0;
            if (ph == 0) begin
                if (start) begin
                    ph = 1; ma = operando_a; mb = operando_b; mop = opcode;
                end
            end else if (ph == 5) begin
                ph = 0;
            end else begin
                ph++;
            end
            if (ph == 1) mbus = '0;
            if (ph == 2) mbus = ma;
            if (ph == 3) mbus = mb;
            if (ph == 4) msel = mop;
        end
        #1;
        etx = mrst || ph == 1 ? 0 : (ph == 2 ? 1 : 2);
        ety = mrst || ph == 1 ? 0 : (ph == 3 ? 1 : 2);
        etz = mrst || ph == 1 ? 0 : (ph == 4 ? 1 : 2);
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("done", 32'(done), 32'(ph == 5));
        chk("Tx", 32'(Tx), 32'(etx));
        chk("Ty", 32'(Ty), 32'(ety));
        chk("Tz", 32'(Tz), 32'(etz));
        chk("barramento", 32'(barramento), 32'(mbus));
        chk("sel_ula", 32'(sel_ula), 32'(msel));
        if (ph == 5) chk("z_result", 32'(z_r), 32'(ula(ma, mb, mop)));
        if (done === 1'b1) begin
            if (track && last_done > 0) chk("done_period", 32'(cyc - last_done), 32'd6);
            last_done = cyc;
        end
    endtask

    task automatic run_to_ph(input int target);
        for (int i = 0; i < 12 && ph != target; i++) tick();
        chk("reach_phase", 32'(ph), 32'(target));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        operando_a = '0; operando_b = '0; opcode = '0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Basic add
        operando_a = 4'h5; operando_b = 4'h3; opcode = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("basic_z", 32'(z_r), 32'h8);

        // Wrap-around add
        operando_a = 4'hF; operando_b = 4'h1; opcode = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("wrap_z", 32'(z_r), 32'h0);

        // start during CARGA_Y is ignored
        operando_a = 4'h2; operando_b = 4'h6; opcode = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        run_to_ph(3);
        operando_a = 4'h9; operando_b = 4'h9; opcode = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ignored_start_z", 32'(z_r), 32'hC);

        // start held high: back-to-back every 6 cycles, operands churning
        track = 1'b1; last_done = 0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            operando_a = 4'($urandom); operando_b = 4'($urandom); opcode = 3'($urandom);
            tick();
        end
        start = 1'b0; track = 1'b0;
        repeat (6) tick();

        // reset during EXEC
        operando_a = 4'h7; operando_b = 4'h4; opcode = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        run_to_ph(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        operando_a = 4'hA; operando_b = 4'h6; opcode = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("after_reset_z", 32'(z_r), 32'h2);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            operando_a = 4'($urandom); operando_b = 4'($urandom); opcode = 3'($urandom);
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0; start = 1'b0;
        repeat (7) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
